// File: rtl/uram_pkg.sv
// uram_pkg
// Shared definitions for the uram_dp_bank memory bank and its lane sub-module.
//   LANE_W / LANE_BYTES : geometry of one 72-bit lane (nine 8-bit bytes)
//   rd_pipe_t           : one stage of the per-lane read output pipeline
//   init_state_e        : states of the zero-initialisation sequencer
package uram_pkg;

    localparam int LANE_W     = 72;
    localparam int LANE_BYTES = 9;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] data;
    } rd_pipe_t;

    typedef enum logic {
        INIT,
        RUN
    } init_state_e;

endpackage

// File: rtl/uram_lane.sv
// uram_lane
// One 72-bit x 2**ADDR_W true-dual-port lane with per-byte write enables and
// the registered array read. Reads are read-first: a read and a write to the
// same address on the same edge return the pre-write contents. The caller
// guarantees the two write ports never target the same address on one edge.
// Ports:
//   clk              : clock
//   re_a / re_b      : load the array-read register from addr_x
//   we_a / we_b      : write strobe, qualified per byte by bwe_x
//   bwe_a / bwe_b    : byte enables, bit k covers wdata_x[8k+7:8k]
//   addr_a / addr_b  : word address
//   wdata_a / wdata_b: write data
//   rdata_a / rdata_b: array-read register (one cycle after re_x)
module uram_lane
    import uram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  re_a,
    input  logic                  we_a,
    input  logic [LANE_BYTES-1:0] bwe_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [LANE_W-1:0]     wdata_a,
    output logic [LANE_W-1:0]     rdata_a,
    input  logic                  re_b,
    input  logic                  we_b,
    input  logic [LANE_BYTES-1:0] bwe_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [LANE_W-1:0]     wdata_b,
    output logic [LANE_W-1:0]     rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [LANE_W-1:0] mem [DEPTH];

    // Non-blocking reads and writes on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (re_a) rdata_a <= mem[addr_a];
        if (re_b) rdata_b <= mem[addr_b];
        for (int k = 0; k < LANE_BYTES; k++) begin
            if (we_a && bwe_a[k]) mem[addr_a][8*k +: 8] <= wdata_a[8*k +: 8];
            if (we_b && bwe_b[k]) mem[addr_b][8*k +: 8] <= wdata_b[8*k +: 8];
        end
    end

endmodule

// File: rtl/uram_dp_bank.sv
// uram_dp_bank
// Parametrised true-dual-port wide memory bank built from NUM_LANES 72-bit
// lanes. Port A is the peer (network) side, port B the host side.
// Owns request qualification, write-write collision arbitration (port A wins,
// port B's write is dropped whole), the zero-init sequencer and the read
// output pipeline (array register + RD_LAT-1 output stages; RD_LAT in 2..4).
// Optional feature: define URAM_ZERO_INIT_EN to sweep zeros through the array
// after reset before init_done rises; otherwise init_done rises one cycle after
// reset and contents are undefined until written.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en_x / wr_x              : request strobe / 1 = write, 0 = read
//   bwe_x, addr_x, wdata_x   : byte enables, word address, write data
//   rdata_x / rvalid_x       : read data (held between strobes) / strobe
//   coll_b                   : pulse, port B write dropped by collision
//   init_done                : bank accepts requests
module uram_dp_bank
    import uram_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_a,
    input  logic                            wr_a,
    input  logic [NUM_LANES*LANE_BYTES-1:0] bwe_a,
    input  logic [ADDR_W-1:0]               addr_a,
    input  logic [NUM_LANES*LANE_W-1:0]     wdata_a,
    output logic [NUM_LANES*LANE_W-1:0]     rdata_a,
    output logic                            rvalid_a,
    input  logic                            en_b,
    input  logic                            wr_b,
    input  logic [NUM_LANES*LANE_BYTES-1:0] bwe_b,
    input  logic [ADDR_W-1:0]               addr_b,
    input  logic [NUM_LANES*LANE_W-1:0]     wdata_b,
    output logic [NUM_LANES*LANE_W-1:0]     rdata_b,
    output logic                            rvalid_b,
    output logic                            coll_b,
    output logic                            init_done
);

    localparam int DW = NUM_LANES * LANE_W;
    localparam int BW = NUM_LANES * LANE_BYTES;

    logic              init_wr;
    logic [ADDR_W-1:0] init_addr;

`ifdef URAM_ZERO_INIT_EN
    init_state_e state;

    // The sweep writes one address per cycle; init_done follows RUN by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= (state == RUN);
            case (state)
                INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (&init_addr) state <= RUN;
                end
                RUN: ;
                default: state <= INIT;
            endcase
        end
    end

    assign init_wr = (state == INIT) && !rst;
`else
    // Without the sweep the bank is ready on the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) init_done <= 1'b0;
        else     init_done <= 1'b1;
    end

    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    logic accept, rd_a, rd_b, wa_ok, wb_ok, ww_coll, wb_eff;
    logic              pa_we;
    logic [ADDR_W-1:0] pa_addr;
    logic [BW-1:0]     pa_bwe;
    logic [DW-1:0]     pa_wdata;

    // init_wr and accept never overlap: init_done stays low for the whole sweep.
    assign accept   = init_done && !rst;
    assign rd_a     = accept && en_a && !wr_a;
    assign rd_b     = accept && en_b && !wr_b;
    assign wa_ok    = accept && en_a && wr_a;
    assign wb_ok    = accept && en_b && wr_b;
    assign ww_coll  = wa_ok && wb_ok && (addr_a == addr_b);
    assign wb_eff   = wb_ok && !ww_coll;

    // The sweep borrows port A's write path.
    assign pa_we    = init_wr || wa_ok;
    assign pa_addr  = init_wr ? init_addr : addr_a;
    assign pa_bwe   = init_wr ? '1 : bwe_a;
    assign pa_wdata = init_wr ? '0 : wdata_a;

    logic [LANE_W-1:0] lane_q_a [NUM_LANES];
    logic [LANE_W-1:0] lane_q_b [NUM_LANES];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        uram_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk     (clk),
            .re_a    (rd_a),
            .we_a    (pa_we),
            .bwe_a   (pa_bwe[l*LANE_BYTES +: LANE_BYTES]),
            .addr_a  (pa_addr),
            .wdata_a (pa_wdata[l*LANE_W +: LANE_W]),
            .rdata_a (lane_q_a[l]),
            .re_b    (rd_b),
            .we_b    (wb_eff),
            .bwe_b   (bwe_b[l*LANE_BYTES +: LANE_BYTES]),
            .addr_b  (addr_b),
            .wdata_b (wdata_b[l*LANE_W +: LANE_W]),
            .rdata_b (lane_q_b[l])
        );
    end

    logic     v0_a, v0_b;
    rd_pipe_t pipe_a [NUM_LANES][RD_LAT-1];
    rd_pipe_t pipe_b [NUM_LANES][RD_LAT-1];

    // Each lane carries its own copy of the strobe; data only advances with a
    // valid strobe so the last stage holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_a   <= 1'b0;
            v0_b   <= 1'b0;
            coll_b <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int s = 0; s < RD_LAT-1; s++) begin
                    pipe_a[l][s] <= '0;
                    pipe_b[l][s] <= '0;
                end
            end
        end else begin
            v0_a   <= rd_a;
            v0_b   <= rd_b;
            coll_b <= ww_coll;
            for (int l = 0; l < NUM_LANES; l++) begin
                pipe_a[l][0].valid <= v0_a;
                pipe_b[l][0].valid <= v0_b;
                if (v0_a) pipe_a[l][0].data <= lane_q_a[l];
                if (v0_b) pipe_b[l][0].data <= lane_q_b[l];
                for (int s = 1; s < RD_LAT-1; s++) begin
                    pipe_a[l][s].valid <= pipe_a[l][s-1].valid;
                    pipe_b[l][s].valid <= pipe_b[l][s-1].valid;
                    if (pipe_a[l][s-1].valid) pipe_a[l][s].data <= pipe_a[l][s-1].data;
                    if (pipe_b[l][s-1].valid) pipe_b[l][s].data <= pipe_b[l][s-1].data;
                end
            end
        end
    end

    // All lane strobe copies are identical; combining them keeps each one live.
    always_comb begin
        rdata_a  = '0;
        rdata_b  = '0;
        rvalid_a = 1'b1;
        rvalid_b = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
            rdata_a[l*LANE_W +: LANE_W] = pipe_a[l][RD_LAT-2].data;
            rdata_b[l*LANE_W +: LANE_W] = pipe_b[l][RD_LAT-2].data;
            rvalid_a = rvalid_a & pipe_a[l][RD_LAT-2].valid;
            rvalid_b = rvalid_b & pipe_b[l][RD_LAT-2].valid;
        end
    end

endmodule

// File: tb/tb_uram_dp_bank.sv
// tb_uram_dp_bank
// Self-checking bench for uram_dp_bank (NUM_LANES=8, ADDR_W=12, RD_LAT=3).
// A word-level memory model with a queue of pending reads predicts every
// output; a vector table and hand sequences add explicit expected values.
// Works with or without URAM_ZERO_INIT_EN defined.
module tb_uram_dp_bank;

    localparam int NUM_LANES = 8;
    localparam int ADDR_W    = 12;
    localparam int RD_LAT    = 3;
    localparam int DW        = NUM_LANES * 72;
    localparam int BW        = NUM_LANES * 9;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_a, wr_a, en_b, wr_b;
    logic [BW-1:0]     bwe_a, bwe_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DW-1:0]     wdata_a, wdata_b, rdata_a, rdata_b;
    logic              rvalid_a, rvalid_b, coll_b, init_done;

    always #5 clk = ~clk;

    uram_dp_bank #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .en_a(en_a), .wr_a(wr_a), .bwe_a(bwe_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .en_b(en_b), .wr_b(wr_b), .bwe_b(bwe_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .coll_b(coll_b), .init_done(init_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Reference model: whole words, pending reads tagged with the edge after
    // which their data must be on the port.
    logic [DW-1:0] model_mem [DEPTH];
    typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
    rd_exp_t       q_a[$], q_b[$];
    logic [DW-1:0] last_a, last_b;
    logic          exp_coll;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b want %b", name, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {BW{b}};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [BW-1:0] rand_bwe();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return BW'({$urandom(), $urandom(), $urandom()});
        endcase
    endfunction

    function automatic void write_model(input logic [ADDR_W-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        for (int k = 0; k < BW; k++)
            if (be[k]) model_mem[a][8*k +: 8] = d[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
    endtask

    // Compares every output against the model for the edge just taken.
    task automatic checkOutput();
        check_bit("init_done", init_done, 1'b1);
        check_bit("coll_b", coll_b, exp_coll);
        if (q_a.size() > 0 && q_a[0].due == edge_no) begin
            check_bit("rvalid_a", rvalid_a, 1'b1);
            check("rdata_a", rdata_a, q_a[0].data);
            last_a = q_a[0].data;
            void'(q_a.pop_front());
        end else begin
            check_bit("rvalid_a idle", rvalid_a, 1'b0);
            check("rdata_a hold", rdata_a, last_a);
        end
        if (q_b.size() > 0 && q_b[0].due == edge_no) begin
            check_bit("rvalid_b", rvalid_b, 1'b1);
            check("rdata_b", rdata_b, q_b[0].data);
            last_b = q_b[0].data;
            void'(q_b.pop_front());
        end else begin
            check_bit("rvalid_b idle", rvalid_b, 1'b0);
            check("rdata_b hold", rdata_b, last_b);
        end
    endtask

    // One bank cycle in RUN: drive, predict, clock, compare.
    task automatic applyStimulus(
        input logic ea, input logic wa, input logic [ADDR_W-1:0] aa, input logic [BW-1:0] ba, input logic [DW-1:0] da,
        input logic eb, input logic wb, input logic [ADDR_W-1:0] ab, input logic [BW-1:0] bb, input logic [DW-1:0] db);
        en_a = ea; wr_a = wa; addr_a = aa; bwe_a = ba; wdata_a = da;
        en_b = eb; wr_b = wb; addr_b = ab; bwe_b = bb; wdata_b = db;
        if (ea && !wa) q_a.push_back('{edge_no + RD_LAT, model_mem[aa]});
        if (eb && !wb) q_b.push_back('{edge_no + RD_LAT, model_mem[ab]});
        exp_coll = ea && wa && eb && wb && (aa == ab);
        if (ea && wa) write_model(aa, ba, da);
        if (eb && wb && !exp_coll) write_model(ab, bb, db);
        tick();
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Pulses reset for one cycle, then waits for init_done while offering
    // requests that must all be ignored; returns cycles from reset release.
    task automatic do_reset(output int n);
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        q_a.delete(); q_b.delete();
        last_a = '0; last_b = '0; exp_coll = 1'b0;
        tick();
        check_bit("rst rvalid_a", rvalid_a, 1'b0);
        check_bit("rst rvalid_b", rvalid_b, 1'b0);
        check_bit("rst init_done", init_done, 1'b0);
        check_bit("rst coll_b", coll_b, 1'b0);
        check("rst rdata_a", rdata_a, '0);
        check("rst rdata_b", rdata_b, '0);
        rst = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < DEPTH + 50) begin
            en_a = 1'b1; wr_a = 1'b0; addr_a = ADDR_W'($urandom());
            en_b = 1'b1; wr_b = 1'b1; addr_b = 12'h005; bwe_b = '1; wdata_b = '1;
            tick();
            n++;
            check_bit("init rvalid_a", rvalid_a, 1'b0);
            check_bit("init rvalid_b", rvalid_b, 1'b0);
            check_bit("init coll_b", coll_b, 1'b0);
        end
        en_a = 1'b0; en_b = 1'b0;
`ifdef URAM_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
    endtask

    typedef struct {
        logic ea, wa; logic [ADDR_W-1:0] aa; logic [BW-1:0] ba; logic [7:0] da;
        logic eb, wb; logic [ADDR_W-1:0] ab; logic [BW-1:0] bb; logic [7:0] db;
        logic exp_coll; logic [DW-1:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int            lat, exp_lat, first, cnt, lastv, e0;
        logic [DW-1:0] mix, lo4;
        logic          ea, wa, eb, wb;
        logic [ADDR_W-1:0] aa, ab;

        rst = 1'b1;
        en_a = 1'b0; wr_a = 1'b0; bwe_a = '0; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; wr_b = 1'b0; bwe_b = '0; addr_b = '0; wdata_b = '0;
        tick();

`ifdef URAM_ZERO_INIT_EN
        exp_lat = DEPTH + 1;
`else
        exp_lat = 1;
`endif
        do_reset(lat);
        check_int("init latency", lat, exp_lat);
`ifndef URAM_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 1'b1, ADDR_W'(i), '1, '0, 1'b0, 1'b0, '0, '0, '0);
`endif
        idle(2);

        // Top address reads back zero after the sweep.
        applyStimulus(1'b1, 1'b0, 12'hFFF, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        idle(RD_LAT - 1);
        check("rd 0xFFF", rdata_a, '0);

        mix = fill(8'hA5);
        mix[7:0] = 8'h3C;
        lo4 = {{(DW-32){1'b0}}, 32'h11111111};
        vecs[0]  = '{1, 1, 12'h010, '1,      8'hA5, 0, 0, 12'h000, '0,     8'h00, 0, '0,          '0};
        vecs[1]  = '{0, 0, 12'h000, '0,      8'h00, 1, 1, 12'h010, 72'h1,  8'h3C, 0, '0,          '0};
        vecs[2]  = '{1, 0, 12'h010, '0,      8'h00, 1, 0, 12'h010, '0,     8'h00, 0, mix,         mix};
        vecs[3]  = '{1, 1, 12'h020, 72'h00F, 8'h11, 1, 1, 12'h020, '1,     8'h22, 1, '0,          '0};
        vecs[4]  = '{1, 0, 12'h020, '0,      8'h00, 0, 0, 12'h000, '0,     8'h00, 0, lo4,         '0};
        vecs[5]  = '{1, 1, 12'h030, '1,      8'h77, 0, 0, 12'h000, '0,     8'h00, 0, '0,          '0};
        vecs[6]  = '{1, 0, 12'h030, '0,      8'h00, 1, 1, 12'h030, '1,     8'h55, 0, fill(8'h77), '0};
        vecs[7]  = '{1, 0, 12'h030, '0,      8'h00, 0, 0, 12'h000, '0,     8'h00, 0, fill(8'h55), '0};
        vecs[8]  = '{0, 0, 12'h000, '0,      8'h00, 1, 1, 12'h040, '0,     8'hFF, 0, '0,          '0};
        vecs[9]  = '{1, 0, 12'h005, '0,      8'h00, 1, 0, 12'h040, '0,     8'h00, 0, '0,          '0};
        vecs[10] = '{1, 1, 12'h050, '1,      8'h99, 1, 0, 12'h050, '0,     8'h00, 0, '0,          '0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].ea, vecs[i].wa, vecs[i].aa, vecs[i].ba, fill(vecs[i].da),
                          vecs[i].eb, vecs[i].wb, vecs[i].ab, vecs[i].bb, fill(vecs[i].db));
            check_bit($sformatf("vec%0d coll_b", i), coll_b, vecs[i].exp_coll);
            idle(RD_LAT - 1);
            if (vecs[i].ea && !vecs[i].wa) check($sformatf("vec%0d rdata_a", i), rdata_a, vecs[i].exp_a);
            if (vecs[i].eb && !vecs[i].wb) check($sformatf("vec%0d rdata_b", i), rdata_b, vecs[i].exp_b);
            idle(1);
        end

        // Read-first then read-after-write on consecutive cycles.
        applyStimulus(1'b1, 1'b1, 12'h070, '1, fill(8'h77), 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 12'h070, '0, '0, 1'b1, 1'b1, 12'h070, '1, fill(8'h55));
        applyStimulus(1'b1, 1'b0, 12'h070, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        idle(1);
        check("rd-first 0x070", rdata_a, fill(8'h77));
        idle(1);
        check("rd-after-wr 0x070", rdata_a, fill(8'h55));
        idle(2);

        // Back-to-back reads on port B over addresses 0..15.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 1'b1, ADDR_W'(i), '1, rand_word(), 1'b0, 1'b0, '0, '0, '0);
        first = -1; cnt = 0; lastv = -1;
        e0 = edge_no + 1;
        for (int i = 0; i < 16 + RD_LAT + 1; i++) begin
            if (i < 16) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, ADDR_W'(i), '0, '0);
            else        idle(1);
            if (rvalid_b === 1'b1) begin
                if (first < 0) first = edge_no;
                cnt++;
                lastv = edge_no;
            end
        end
        check_int("b2b first rvalid edge", first, e0 + RD_LAT - 1);
        check_int("b2b rvalid count", cnt, 16);
        check_int("b2b rvalid span", lastv - first + 1, 16);

        // Randomised traffic over a small address window to force collisions.
        for (int c = 0; c < 400; c++) begin
            ea = ($urandom_range(0, 3) != 0);
            wa = $urandom_range(0, 1) == 1;
            eb = ($urandom_range(0, 3) != 0);
            wb = $urandom_range(0, 1) == 1;
            aa = ADDR_W'(12'h100 + $urandom_range(0, 7));
            ab = ADDR_W'(12'h100 + $urandom_range(0, 7));
            applyStimulus(ea, wa, aa, rand_bwe(), rand_word(), eb, wb, ab, rand_bwe(), rand_word());
        end
        idle(RD_LAT + 1);

        // Reset with two reads in flight: both must vanish.
        applyStimulus(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 12'h020, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        do_reset(lat);
        check_int("re-init latency", lat, exp_lat);
        idle(RD_LAT);
        applyStimulus(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        idle(RD_LAT - 1);
`ifdef URAM_ZERO_INIT_EN
        check("post-reset 0x010", rdata_a, '0);
`else
        check("post-reset 0x010", rdata_a, mix);
`endif
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uram_dp_bank.md
# uram_dp_bank

Parametrised true-dual-port wide memory bank, the successor to the fixed 576-bit, 8-lane URAM array in the UDP datapath. Width is set in 72-bit lanes and depth by address width. The block adds a registered read pipeline with valid strobes, write-collision arbitration between ports, and optional zero-initialisation after reset. Port A serves the peer (network) side and port B the host side.

## Interface
- NUM_LANES, 8, number of 72-bit lanes; data width DW = NUM_LANES*72
- ADDR_W, 12, word address width; DEPTH = 2**ADDR_W
- RD_LAT, 3, read latency in cycles, legal range 2..4
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- en_a / en_b  in  1  request strobe, port A / port B
- wr_a / wr_b  in  1  1 = write, 0 = read; qualified by en_x
- bwe_a / bwe_b  in  NUM_LANES*9  per-byte write enables; bit k covers data bits [8k+7:8k]
- addr_a / addr_b  in  ADDR_W  word address
- wdata_a / wdata_b  in  DW  write data
- rdata_a / rdata_b  out  DW  read data; reset 0
- rvalid_a / rvalid_b  out  1  one-cycle read-data strobe; reset 0
- coll_b  out  1  pulse: port B write dropped by collision; reset 0
- init_done  out  1  bank accepts requests; reset 0

## Operation
- Requests are accepted only while init_done=1. While init_done=0, en_x is ignored and no rvalid is produced.
- Write: each byte with bwe set is updated. Bytes with bwe clear keep their old value. A write with bwe all-zero is a legal no-op.
- Read: returns the full DW word. The read is read-first: if the other port writes the same address in the same cycle, the read returns the pre-write data.
- Write-write collision means same cycle, same addr, both en and wr. Port A wins on every byte. Port B's write is dropped entirely, including bytes that A does not enable. coll_b pulses for 1 cycle at T+1.
- Read-read on the same address: both ports return identical data.
- Init FSM has states INIT and RUN.
  - After rst falls, the FSM is in INIT and writes zero to addresses 0..DEPTH-1, one per cycle, through an internal write path.
  - After the last address is written, it moves to RUN and sets init_done=1 on the following cycle.
- Reset asserted mid-operation: every in-flight read is discarded, rvalid and rdata are cleared, init_done is cleared, and the INIT sweep restarts at address 0.

## Timing
- Read accepted at cycle T gives rdata_x and rvalid_x at T+RD_LAT.
  - Pipeline = 1 array-read stage + (RD_LAT-1) output registers.
  - Fully pipelined: one request per port per cycle; back-to-back reads give back-to-back rvalid.
- rdata_x holds its last value when rvalid_x=0.
- Write at cycle T is visible to a read from either port at T+1 or later.
- INIT duration: rst deasserted at cycle 0 gives init_done=1 at cycle DEPTH+1.

## Configuration
- URAM_ZERO_INIT_EN defined: the INIT sweep runs as described above.
- URAM_ZERO_INIT_EN undefined:
  - The FSM is fixed in RUN and init_done=1 on the first cycle after rst deasserts.
  - Memory contents are undefined until written.
  - All other behaviour is identical.

## Structure
- Package uram_pkg holds:
  - LANE_W=72 and LANE_BYTES=9
  - typedef rd_pipe_t {valid, data}
  - enum init_state_e {INIT, RUN}
- Sub-module uram_lane holds one 72-bit × DEPTH true-dual-port lane with per-byte enables and the array-read register.
  - It is instantiated NUM_LANES times from a generate loop.
  - The top level owns arbitration, the init FSM and the output pipeline.

## Test plan
- NUM_LANES=8, ADDR_W=12, RD_LAT=3, macro on: after reset, init_done rises at cycle 4097. A read of addr 0xFFF then returns 0 with rvalid 3 cycles later.
- Port A writes addr 0x010 with 0xA5 in all bytes and bwe all ones. Port B then writes 0x3C to addr 0x010 with only bwe[0] set. A later read of 0x010 returns byte0=0x3C and every other byte 0xA5.
- Same cycle, both ports write addr 0x020: A writes 0x11 with bwe=0x00F, B writes 0x22 with bwe all ones. Read of 0x020 returns 0x11 in bytes 0–3 and 0 elsewhere. coll_b=1 for exactly one cycle.
- Same cycle, A reads and B writes 0x55.. to addr 0x030, which holds 0x77..: A returns 0x77.. A read of 0x030 on the next cycle returns 0x55..
- 16 back-to-back reads on port B, addr 0..15: rvalid_b is high for 16 consecutive cycles starting at T+3, with data in address order.
- rst pulsed for 1 cycle while 2 reads are in flight: neither rvalid appears, init_done drops, and the INIT sweep restarts. With the macro off, init_done=1 one cycle after reset.
